// File: rtl/afifo_tb_pkg.sv
// Types shared by the asynchronous FIFO producer side and its write arbiter.
package afifo_tb_pkg;

  typedef logic [7:0] data_t;
  typedef logic       bit_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } afifo_arb_state_t;

endpackage

// File: rtl/afifo_rr_pick.sv
// Round-robin picker: first asserted request strictly after ptr, wrapping so ptr itself comes last.
module afifo_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] slot;

  // Walk from the farthest slot back to the nearest so the nearest valid one wins.
  always_comb begin
    idx  = '0;
    slot = '0;
    any  = |req;
    for (int k = N_REQ; k >= 1; k--) begin
      slot = IDX_W'((int'(ptr) + k) % N_REQ);
      if (req[slot]) idx = slot;
    end
  end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Shares the FIFO push port between N_REQ write-domain producers with bounded-burst round robin.
module afifo_wr_arbiter
  import afifo_tb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BURST = 4,
  parameter int CNT_W = 16
) (
  input  logic              wrclk,
  input  logic              wr_rst,
  input  logic [N_REQ-1:0]  req_valid,
  input  data_t             req_data [N_REQ],
  output logic [N_REQ-1:0]  req_ready,
  input  logic              full,
  output logic              push,
  output data_t             data_in,
  output logic [N_REQ-1:0]  grant,
  output logic [CNT_W-1:0]  push_cnt
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;

  afifo_arb_state_t  state_q, state_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]  last_ptr_q, last_ptr_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  push_cnt_q, push_cnt_d;

  logic [IDX_W-1:0]  idleIdx, relIdx;
  logic              idleAny, relAny;
  logic              inGrant, ownerValid, lastBeat, releaseNow;

  afifo_rr_pick #(.N_REQ(N_REQ)) u_pick_idle (
    .req (req_valid),
    .ptr (last_ptr_q),
    .idx (idleIdx),
    .any (idleAny)
  );

  afifo_rr_pick #(.N_REQ(N_REQ)) u_pick_release (
    .req (req_valid),
    .ptr (gnt_idx_q),
    .idx (relIdx),
    .any (relAny)
  );

  // Reset gates every producer-facing output so nothing leaks out during the first reset cycle.
  always_comb begin
    inGrant    = (state_q == GRANT) && wr_rst;
    ownerValid = req_valid[gnt_idx_q];
    push       = inGrant && ownerValid && !full;
    lastBeat   = (beat_cnt_q == BEAT_W'(BURST - 1));
    releaseNow = inGrant && ((push && lastBeat) || !ownerValid);
    req_ready  = '0;
    grant      = '0;
    if (inGrant) begin
      req_ready[gnt_idx_q] = !full;
      grant[gnt_idx_q]     = 1'b1;
    end
    data_in = push ? req_data[gnt_idx_q] : '0;
  end

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_ptr_d = last_ptr_q;
    beat_cnt_d = beat_cnt_q;
    push_cnt_d = push_cnt_q + CNT_W'(push);
    if (state_q == IDLE) begin
      if (idleAny) begin
        state_d    = GRANT;
        gnt_idx_d  = idleIdx;
        beat_cnt_d = '0;
      end
    end else if (releaseNow) begin
      last_ptr_d = gnt_idx_q;
      beat_cnt_d = '0;
      if (relAny) begin
        gnt_idx_d = relIdx;
      end else begin
        state_d = IDLE;
      end
    end else if (push) begin
      beat_cnt_d = beat_cnt_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge wrclk) begin
    if (!wr_rst) begin
      state_q    <= IDLE;
      gnt_idx_q  <= '0;
      last_ptr_q <= IDX_W'(N_REQ - 1);
      beat_cnt_q <= '0;
      push_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_ptr_q <= last_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      push_cnt_q <= push_cnt_d;
    end
  end

  assign push_cnt = push_cnt_q;

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Directed bench for afifo_wr_arbiter with a cycle-level reference model and literal pinning checks.
module tb_afifo_wr_arbiter;
  import afifo_tb_pkg::*;

  localparam int N     = 4;
  localparam int BURST = 4;
  localparam int CNT_W = 16;

  logic             wrclk = 1'b0;
  logic             wr_rst;
  logic [N-1:0]     req_valid;
  data_t            req_data [N];
  logic [N-1:0]     req_ready;
  logic             full;
  logic             push;
  data_t            data_in;
  logic [N-1:0]     grant;
  logic [CNT_W-1:0] push_cnt;

  int cmpCount = 0;
  int errCount = 0;

  int beatsLeft [N];
  logic [N-1:0] accepted = '0;

  int               owner     = -1;
  int               lastPtr   = N - 1;
  int               burstUsed = 0;
  logic [CNT_W-1:0] mdlCnt    = '0;
  int               cycle     = 0;

  int    logId[$];
  data_t logData[$];
  int    logCycle[$];

  afifo_wr_arbiter #(.N_REQ(N), .BURST(BURST), .CNT_W(CNT_W)) dut (
    .wrclk     (wrclk),
    .wr_rst    (wr_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .full      (full),
    .push      (push),
    .data_in   (data_in),
    .grant     (grant),
    .push_cnt  (push_cnt)
  );

  always #5 wrclk = ~wrclk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    cmpCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int rrPick(input int ptr, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Reference model: evaluate what the outputs must be this cycle, then advance to the next cycle.
  always @(negedge wrclk) begin
    logic [N-1:0] expGrant, expReady;
    logic         expPush;
    data_t        expData;
    cycle++;
    expGrant = '0;
    expReady = '0;
    expPush  = 1'b0;
    expData  = '0;
    if (wr_rst && owner >= 0) begin
      expGrant[owner] = 1'b1;
      expReady[owner] = !full;
      expPush         = req_valid[owner] && !full;
      if (expPush) expData = req_data[owner];
    end
    checkOutput("push", 32'(push), 32'(expPush));
    checkOutput("grant", 32'(grant), 32'(expGrant));
    checkOutput("req_ready", 32'(req_ready), 32'(expReady));
    checkOutput("data_in", 32'(data_in), 32'(expData));
    checkOutput("push_cnt", 32'(push_cnt), 32'(mdlCnt));
    if (push === 1'b1) begin
      int id;
      id = -1;
      for (int i = 0; i < N; i++) if (grant[i]) id = i;
      logId.push_back(id);
      logData.push_back(data_in);
      logCycle.push_back(cycle);
    end
    accepted = req_valid & expReady;
    if (!wr_rst) begin
      owner     = -1;
      lastPtr   = N - 1;
      burstUsed = 0;
      mdlCnt    = '0;
    end else if (owner < 0) begin
      if (|req_valid) begin
        owner     = rrPick(lastPtr, req_valid);
        burstUsed = 0;
      end
    end else begin
      if (expPush) begin
        mdlCnt++;
        burstUsed++;
      end
      if (burstUsed == BURST || !req_valid[owner]) begin
        lastPtr   = owner;
        owner     = (|req_valid) ? rrPick(owner, req_valid) : -1;
        burstUsed = 0;
      end
    end
  end

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) req_valid[i] = (beatsLeft[i] != 0);
    #1;
  endtask

  // Each producer presents a fresh data word after every accepted beat.
  task automatic tick();
    @(posedge wrclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (accepted[i]) begin
        req_data[i] = req_data[i] + 8'd1;
        if (beatsLeft[i] > 0) beatsLeft[i]--;
      end
    end
    applyStimulus();
  endtask

  task automatic clearLog();
    logId.delete();
    logData.delete();
    logCycle.delete();
  endtask

  task automatic doReset();
    wr_rst = 1'b0;
    full   = 1'b0;
    for (int i = 0; i < N; i++) begin
      beatsLeft[i] = 0;
      req_data[i]  = data_t'(i * 16);
    end
    applyStimulus();
    tick();
    tick();
    wr_rst = 1'b1;
    applyStimulus();
    clearLog();
  endtask

  task automatic runUntil(input int nPush);
    int guard;
    guard = 0;
    while (logId.size() < nPush && guard < 60) begin
      tick();
      guard++;
    end
  endtask

  task automatic checkLog(input string name, input int ids[], input data_t dats[]);
    checkOutput({name, "_count"}, 32'(logId.size()), 32'(ids.size()));
    for (int k = 0; k < ids.size() && k < logId.size(); k++) begin
      checkOutput($sformatf("%s_id%0d", name, k), 32'(logId[k]), 32'(ids[k]));
      checkOutput($sformatf("%s_data%0d", name, k), 32'(logData[k]), 32'(dats[k]));
    end
  endtask

  initial begin
    int    ids[];
    data_t dats[];

    // Reset held for two cycles with every producer requesting.
    wr_rst = 1'b0;
    full   = 1'b0;
    for (int i = 0; i < N; i++) begin
      beatsLeft[i] = -1;
      req_data[i]  = data_t'(i * 16);
    end
    applyStimulus();
    checkOutput("rst_push", 32'(push), 32'd0);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    tick();
    checkOutput("rst_push_cnt", 32'(push_cnt), 32'd0);
    checkOutput("rst_push2", 32'(push), 32'd0);
    tick();
    wr_rst = 1'b1;
    applyStimulus();
    checkOutput("rst_idle_grant", 32'(grant), 32'd0);
    tick();
    checkOutput("rst_first_grant", 32'(grant), 32'b0001);
    checkOutput("rst_first_data", 32'(data_in), 32'h00);

    $display("[TB] round robin between requesters 0 and 2");
    doReset();
    beatsLeft[0] = -1;
    beatsLeft[2] = -1;
    applyStimulus();
    runUntil(12);
    checkOutput("rr_push_cnt", 32'(push_cnt), 32'd12);
    ids  = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0};
    dats = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h20, 8'h21, 8'h22, 8'h23, 8'h04, 8'h05, 8'h06, 8'h07};
    checkLog("rr", ids, dats);
    if (logCycle.size() == 12) checkOutput("rr_no_gaps", 32'(logCycle[11] - logCycle[0]), 32'd11);

    $display("[TB] early release of requester 1");
    doReset();
    beatsLeft[1] = 2;
    beatsLeft[3] = -1;
    applyStimulus();
    runUntil(4);
    ids  = '{1, 1, 3, 3};
    dats = '{8'h10, 8'h11, 8'h30, 8'h31};
    checkLog("early", ids, dats);

    $display("[TB] full stall mid-burst");
    doReset();
    beatsLeft[0] = -1;
    beatsLeft[1] = -1;
    applyStimulus();
    runUntil(2);
    full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      checkOutput("stall_push", 32'(push), 32'd0);
      checkOutput("stall_ready", 32'(req_ready), 32'd0);
      checkOutput("stall_grant", 32'(grant), 32'b0001);
      tick();
    end
    full = 1'b0;
    applyStimulus();
    runUntil(5);
    ids  = '{0, 0, 0, 0, 1};
    dats = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10};
    checkLog("stall", ids, dats);

    $display("[TB] reset during a burst of requester 2");
    doReset();
    beatsLeft[2] = -1;
    applyStimulus();
    runUntil(1);
    beatsLeft[0] = -1;
    wr_rst = 1'b0;
    applyStimulus();
    checkOutput("mrst_push", 32'(push), 32'd0);
    checkOutput("mrst_grant", 32'(grant), 32'd0);
    checkOutput("mrst_data", 32'(data_in), 32'd0);
    tick();
    checkOutput("mrst_push_cnt", 32'(push_cnt), 32'd0);
    wr_rst = 1'b1;
    applyStimulus();
    checkOutput("mrst_idle_grant", 32'(grant), 32'd0);
    tick();
    checkOutput("mrst_first_grant", 32'(grant), 32'b0001);

    $display("[TB] single requester 3 for ten beats");
    doReset();
    beatsLeft[3] = 10;
    applyStimulus();
    runUntil(10);
    for (int c = 0; c < 3; c++) tick();
    ids  = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    dats = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    checkLog("single", ids, dats);
    checkOutput("single_push_cnt", 32'(push_cnt), 32'd10);
    if (logCycle.size() == 10) checkOutput("single_no_gaps", 32'(logCycle[9] - logCycle[0]), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
